// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between the
// in-order core writeback (A, priority) and a long-latency unit (B, buffered
// in a small FIFO). A starvation guard forces B through after it has waited
// STARVE_LIMIT cycles. Registered outputs drive the register file directly.
//
// Optional feature: define WB_SCOREBOARD_EN to compile in the pending-write
// mask that raises rs1_hazard/rs2_hazard for registers with a B write in
// flight. Without it the hazards are tied low and busy_* are ignored.
module regfile_wb_arbiter #(
    parameter int B_DEPTH      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [4:0]               a_addr,
    input  logic [31:0]              a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [4:0]               b_addr,
    input  logic [31:0]              b_data,
    input  logic                     busy_set,
    input  logic [4:0]               busy_addr,
    input  logic [4:0]               rs1_addr,
    input  logic [4:0]               rs2_addr,
    output logic                     rs1_hazard,
    output logic                     rs2_hazard,
    output logic                     reg_w,
    output logic [4:0]               rd_addr,
    output logic [31:0]              rd_data,
    output logic [$clog2(B_DEPTH):0] b_count
);

    localparam int PTR_W = $clog2(B_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        A_PRIO  = 1'b0,
        FORCE_B = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [STV_W-1:0]   starve_q, starve_d;

    logic [4:0]         fifo_addr [B_DEPTH];
    logic [31:0]        fifo_data [B_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               fifo_empty;
    logic               push, pop;

    logic               grant, grant_b;
    logic [4:0]         g_addr;
    logic [31:0]        g_data;

    assign fifo_empty = (count_q == '0);
    // Full blocks a push even when the head is popped in the same cycle.
    assign b_ready    = (count_q < CNT_W'(B_DEPTH));
    assign push       = b_valid && b_ready;
    assign b_count    = count_q;

    // Arbitration, starvation tracking and next-state selection.
    always_comb begin
        state_d  = A_PRIO;
        a_ready  = 1'b0;
        pop      = 1'b0;
        grant    = 1'b0;
        grant_b  = 1'b0;
        g_addr   = '0;
        g_data   = '0;
        starve_d = starve_q;
        case (state_q)
            A_PRIO: begin
                a_ready = 1'b1;
                if (a_valid) begin
                    grant  = 1'b1;
                    g_addr = a_addr;
                    g_data = a_data;
                end else if (!fifo_empty) begin
                    grant   = 1'b1;
                    grant_b = 1'b1;
                    pop     = 1'b1;
                    g_addr  = fifo_addr[rd_ptr];
                    g_data  = fifo_data[rd_ptr];
                end
            end
            FORCE_B: begin
                if (!fifo_empty) begin
                    grant   = 1'b1;
                    grant_b = 1'b1;
                    pop     = 1'b1;
                    g_addr  = fifo_addr[rd_ptr];
                    g_data  = fifo_data[rd_ptr];
                end
            end
            default: ;
        endcase
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q + STV_W'(1);
        end
        // Entering FORCE_B on the same edge the count reaches the limit
        // makes the forced grant land STARVE_LIMIT+1 cycles after the push.
        if (state_q == A_PRIO && starve_d == STV_W'(STARVE_LIMIT)) begin
            state_d = FORCE_B;
        end
    end

    // Control state: FSM and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= A_PRIO;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= b_addr;
            fifo_data[wr_ptr] <= b_data;
        end
    end

    // Write-port register: one pulse per grant, x0 grants consumed silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_w   <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else if (grant) begin
            reg_w   <= (g_addr != 5'd0);
            rd_addr <= g_addr;
            rd_data <= g_data;
        end else begin
            reg_w   <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] pending_q;
    logic [31:0] set_mask, clr_mask;

    // Build set/clear masks; x0 is never marked pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (busy_set && busy_addr != 5'd0) set_mask[busy_addr] = 1'b1;
        if (grant_b) clr_mask[g_addr] = 1'b1;
    end

    // Pending mask; a set on the same edge as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_mask) | set_mask;
        end
    end

    assign rs1_hazard = pending_q[rs1_addr];
    assign rs2_hazard = pending_q[rs2_addr];
`else
    logic unused_sb;
    assign unused_sb  = ^{busy_set, busy_addr, rs1_addr, rs2_addr, grant_b};
    assign rs1_hazard = 1'b0;
    assign rs2_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int B_DEPTH      = 2;
    localparam int STARVE_LIMIT = 4;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid, a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid, b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        busy_set;
    logic [4:0]  busy_addr, rs1_addr, rs2_addr;
    logic        rs1_hazard, rs2_hazard;
    logic        reg_w;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [$clog2(B_DEPTH):0] b_count;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.B_DEPTH(B_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard),
        .reg_w(reg_w), .rd_addr(rd_addr), .rd_data(rd_data), .b_count(b_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_wait;
    bit          m_force;
    logic        m_regw;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_pend;

    task automatic model_reset();
        mq.delete();
        m_wait  = 0;
        m_force = 1'b0;
        m_regw  = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_pend  = '0;
    endtask

    // Advance one clock edge using the inputs that will be sampled there.
    task automatic model_step();
        int   n;
        bit   popped;
        ent_t h;
        n      = mq.size();
        popped = 1'b0;
        h      = '0;
        if (!m_force && a_valid) begin
            m_regw = (a_addr != 0);
            m_addr = a_addr;
            m_data = a_data;
        end else if (n > 0) begin
            h      = mq.pop_front();
            popped = 1'b1;
            m_regw = (h.addr != 0);
            m_addr = h.addr;
            m_data = h.data;
        end else begin
            m_regw = 1'b0;
            m_addr = '0;
            m_data = '0;
        end
        if (b_valid && n < B_DEPTH) mq.push_back({b_addr, b_data});
        if (n == 0 || popped) m_wait = 0;
        else m_wait++;
        m_force = (m_wait == STARVE_LIMIT);
        if (popped) m_pend[h.addr] = 1'b0;
        if (busy_set && busy_addr != 0) m_pend[busy_addr] = 1'b1;
    endtask

    initial model_reset();

    // Per-cycle compare on the falling edge, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            chk("a_ready",    a_ready,    !m_force);
            chk("b_ready",    b_ready,    mq.size() < B_DEPTH);
            chk("b_count",    b_count,    mq.size());
            chk("reg_w",      reg_w,      m_regw);
            chk("rd_addr",    rd_addr,    m_addr);
            chk("rd_data",    rd_data,    m_data);
            chk("rs1_hazard", rs1_hazard, SB ? m_pend[rs1_addr] : 1'b0);
            chk("rs2_hazard", rs2_hazard, SB ? m_pend[rs2_addr] : 1'b0);
            if (!rst) model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        busy_set = 0; busy_addr = 0; rs1_addr = 0; rs2_addr = 0;
    endtask

    initial begin
        int a_pct;
        idle_inputs();
        #1 rst = 1'b1;
        #2;
        chk("rst a_ready", a_ready, 1'b1);
        chk("rst b_ready", b_ready, 1'b1);
        chk("rst b_count", b_count, 0);
        chk("rst reg_w",   reg_w,   1'b0);
        chk("rst rd_addr", rd_addr, 0);
        chk("rst rd_data", rd_data, 0);
        chk("rst rs1_haz", rs1_hazard, 1'b0);
        chk("rst rs2_haz", rs2_hazard, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // A only
        a_valid = 1; a_addr = 5; a_data = 32'h1234;
        tick();
        chk("A reg_w",   reg_w,   1'b1);
        chk("A rd_addr", rd_addr, 5);
        chk("A rd_data", rd_data, 32'h1234);
        a_valid = 0;
        tick();
        chk("A idle reg_w",   reg_w,   1'b0);
        chk("A idle rd_addr", rd_addr, 0);
        chk("A idle rd_data", rd_data, 0);

        // B only
        b_valid = 1; b_addr = 7; b_data = 32'hAA;
        tick();
        chk("B count1",  b_count, 1);
        chk("B reg_w0",  reg_w,   1'b0);
        b_valid = 0;
        tick();
        chk("B reg_w",   reg_w,   1'b1);
        chk("B rd_addr", rd_addr, 7);
        chk("B count0",  b_count, 0);
        tick();

        // Starvation: A held high, one B entry
        a_valid = 1; a_addr = 3; a_data = 32'h33;
        b_valid = 1; b_addr = 8; b_data = 32'hBB;
        tick();
        b_valid = 0;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("starve a_ready", a_ready, (k == 5) ? 1'b0 : 1'b1);
            chk("starve A addr",  rd_addr, 3);
        end
        tick();
        chk("starve B addr",  rd_addr, 8);
        chk("starve B data",  rd_data, 32'hBB);
        chk("starve a_ready back", a_ready, 1'b1);
        chk("starve count",   b_count, 0);

        // FIFO full with wrap-around third push
        b_valid = 1; b_addr = 10; b_data = 32'h10;
        tick();
        b_addr = 11; b_data = 32'h11;
        tick();
        chk("full b_ready", b_ready, 1'b0);
        chk("full count",   b_count, 2);
        b_addr = 12; b_data = 32'h12;
        tick(); tick(); tick();
        chk("full forced", a_ready, 1'b0);
        tick();
        chk("full pop addr", rd_addr, 10);
        chk("full b_ready back", b_ready, 1'b1);
        chk("full count after pop", b_count, 1);
        tick();
        chk("wrap push count", b_count, 2);
        chk("wrap A addr", rd_addr, 3);
        b_valid = 0; a_valid = 0;
        tick();
        chk("drain 11", rd_addr, 11);
        tick();
        chk("drain 12", rd_addr, 12);
        chk("drain 12 data", rd_data, 32'h12);
        chk("drain count", b_count, 0);

        // Scoreboard
        busy_set = 1; busy_addr = 9;
        tick();
        busy_set = 0; rs1_addr = 9;
        #1 chk("sb hazard set", rs1_hazard, SB);
        b_valid = 1; b_addr = 9; b_data = 32'h99;
        tick();
        b_valid = 0;
        chk("sb hazard held", rs1_hazard, SB);
        tick();
        chk("sb B write addr", rd_addr, 9);
        chk("sb hazard cleared", rs1_hazard, 1'b0);
        busy_set = 1; busy_addr = 0; rs2_addr = 0;
        tick();
        busy_set = 0;
        chk("sb x0 hazard", rs2_hazard, 1'b0);

        // x0 write and async reset with a full FIFO
        a_valid = 1; a_addr = 0; a_data = 32'h55;
        #1 chk("x0 a_ready", a_ready, 1'b1);
        tick();
        chk("x0 reg_w", reg_w, 1'b0);
        chk("x0 rd_data", rd_data, 32'h55);
        a_addr = 4; a_data = 32'h44;
        b_valid = 1; b_addr = 13; b_data = 32'h13;
        tick();
        b_addr = 14; b_data = 32'h14;
        tick();
        chk("pre-rst count", b_count, 2);
        chk("pre-rst reg_w", reg_w, 1'b1);
        b_valid = 0; a_valid = 0;
        #1 rst = 1'b1;
        #1;
        chk("async rst count", b_count, 0);
        chk("async rst reg_w", reg_w, 1'b0);
        chk("async rst b_ready", b_ready, 1'b1);
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post-rst reg_w", reg_w, 1'b0);
            chk("post-rst count", b_count, 0);
        end

        // Randomized traffic
        a_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0:       a_pct = 20;
                    1:       a_pct = 60;
                    default: a_pct = 95;
                endcase
            end
            a_valid   = ($urandom_range(0, 99) < a_pct);
            a_addr    = 5'($urandom_range(0, 31));
            a_data    = $urandom();
            b_valid   = ($urandom_range(0, 99) < 45);
            b_addr    = 5'($urandom_range(0, 31));
            b_data    = $urandom();
            busy_set  = ($urandom_range(0, 99) < 30);
            busy_addr = 5'($urandom_range(0, 31));
            rs1_addr  = 5'($urandom_range(0, 31));
            rs2_addr  = 5'($urandom_range(0, 31));
            rst       = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scheduler for the single-write-port register file. It shares the one write port between the in-order core writeback (requester A) and a long-latency unit such as a multi-cycle divider or load unit (requester B). B results are buffered in a small FIFO, and a starvation guard ensures B always drains. An optional scoreboard flags reads of registers that still have a B write in flight. The block's registered outputs drive the register file's write enable, address and data directly.

## Interface
Parameters:
- B_DEPTH, 2: requester-B FIFO depth; power of two, minimum 2.
- STARVE_LIMIT, 4: cycles a non-empty B FIFO may wait before B is forced; minimum 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- a_valid  in  1  core writeback request.
- a_ready  out  1  A accepted on the edge where a_valid && a_ready.
- a_addr  in  5  A destination register.
- a_data  in  32  A write data.
- b_valid  in  1  long-latency result valid.
- b_ready  out  1  B FIFO can accept; equals (count < B_DEPTH).
- b_addr  in  5  B destination register.
- b_data  in  32  B write data.
- busy_set  in  1  B operation issued; marks busy_addr pending.
- busy_addr  in  5  destination of the issued B operation.
- rs1_addr, rs2_addr  in  5 each  read addresses from decode.
- rs1_hazard, rs2_hazard  out  1 each  read address has a pending B write.
- reg_w  out  1  register-file write enable, one-cycle pulse per grant.
- rd_addr  out  5  register-file write address.
- rd_data  out  32  register-file write data.
- b_count  out  $clog2(B_DEPTH)+1  B FIFO occupancy.

## Operation
- State machine has two states.
  - A_PRIO (reset state): a_ready=1.
    - If a_valid, grant A.
    - Else, if the FIFO is non-empty, grant the FIFO head and pop it.
  - FORCE_B: a_ready=0. Grant and pop the FIFO head, clear the starvation counter, then return to A_PRIO.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and its head is not popped.
  - Clears on any pop, and whenever the FIFO is empty.
  - When the counter equals STARVE_LIMIT at a rising edge, the next state is FORCE_B.
- On grant, the output register loads:
  - reg_w=1 if the granted address is non-zero; x0 writes are consumed with reg_w=0.
  - rd_addr and rd_data take the granted address and data.
- With no grant, reg_w, rd_addr and rd_data are all 0.
- FIFO:
  - Push on b_valid && b_ready.
  - Push and pop in the same cycle are legal whenever not full.
  - When full, b_ready=0 even if a pop occurs that cycle.
  - Pointers wrap modulo B_DEPTH.
- Scoreboard: 32-bit pending mask.
  - busy_set sets bit busy_addr.
  - A B grant clears bit rd_addr.
  - A simultaneous set and clear of the same bit resolves to set.
  - Bit 0 is never set.
- Hazard outputs are combinational: rsN_hazard = pending[rsN_addr].

## Timing
- Reset values: a_ready=1, b_ready=1, b_count=0, reg_w=0, rd_addr=0, rd_data=0, hazards=0. State A_PRIO, counter 0, FIFO empty, mask clear.
- Latency:
  - An A transfer accepted at edge t appears on reg_w/rd_* during cycle t→t+1. The register file commits it on that cycle's falling edge.
  - A B transfer pushed at edge t is granted at the earliest at edge t+1, so its write appears one cycle later than an A write.
- reg_w is never high for two grants at once: exactly one grant per cycle at most.
- Reset asserted mid-operation immediately forces all outputs to reset values. FIFO contents and pending marks are discarded. The issuing side must re-issue.
- Hazard outputs reflect the mask after the most recent edge. A register cleared at edge t reads hazard-free in cycle t→t+1, while its write commits on that cycle's falling edge.

## Configuration
- WB_SCOREBOARD_EN defined: the pending mask and hazard logic are compiled in as described.
- WB_SCOREBOARD_EN undefined: no mask storage, busy_set and busy_addr are ignored, and rs1_hazard and rs2_hazard are tied to 0. Arbitration and FIFO behaviour are unchanged.

## Test plan
- A only: a_valid with (x5, 0x1234) at edge 1 → cycle 1–2 shows reg_w=1, rd_addr=5, rd_data=0x1234; cycle 2–3 shows reg_w=0 and rd_* = 0.
- B only: push (x7, 0xAA) at edge 1 → b_count=1, grant at edge 2, reg_w=1 with rd_addr=7 in cycle 2–3, b_count=0.
- Starvation: a_valid held high, one B entry pushed, STARVE_LIMIT=4 → B written exactly 5 cycles after its push. a_ready=0 for that single cycle, then returns to 1.
- FIFO full, B_DEPTH=2, a_valid high: push 2 entries → b_ready=0. When an entry is forced out, b_ready=1 the following cycle and the wrap-around third push is accepted.
- Scoreboard (WB_SCOREBOARD_EN): busy_set on x9 → rs1_addr=9 gives rs1_hazard=1. When B writes x9, hazard=0 after the grant edge. busy_set x0 → never a hazard.
- x0 and reset: A write to x0 → a_ready=1, reg_w=0. Async rst asserted while the FIFO holds 2 entries → b_count=0 and reg_w=0 immediately, no writes after release.
